// File: rtl/alu_mult_div.sv
// Iterative signed MULT (Booth radix-2) / DIV (restoring) unit writing HI/LO.
// Define ALU_MULTDIV_FAST_MULT_EN to replace the Booth sequencer with a single-cycle multiplier.
module alu_mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        accept;

  // Product register {acc[32:0], q[31:0], q_1}; the accumulator carries one guard bit so
  // subtracting a multiplicand of -2^31 cannot overflow before the arithmetic shift.
  logic [65:0] prod;
  logic [65:0] booth_nxt;
  logic [32:0] acc_sum;
  logic [31:0] m_r;
  logic [31:0] rem_r, quo_r;
  logic [32:0] div_sh, div_diff;
  logic        sign_a, sign_b, is_div, dz_r;
  logic [31:0] quo_fin, rem_fin;

  assign accept = (state == S_IDLE) && start && (op == OP_MULT || op == OP_DIV);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && op == OP_MULT) begin
`ifdef ALU_MULTDIV_FAST_MULT_EN
          state_nxt = S_FINISH;
`else
          state_nxt = S_MULT;
`endif
        end else if (accept) begin
          state_nxt = (src_b == 32'd0) ? S_FINISH : S_DIV;
        end
      end
      S_MULT, S_DIV: if (cnt == 5'd31) state_nxt = S_FINISH;
      S_FINISH:      state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // One Booth step: add/subtract M on {q0, q_1} = 01/10, then arithmetic shift right.
  always_comb begin
    acc_sum = prod[65:33];
    case (prod[1:0])
      2'b01:   acc_sum = prod[65:33] + {m_r[31], m_r};
      2'b10:   acc_sum = prod[65:33] - {m_r[31], m_r};
      default: acc_sum = prod[65:33];
    endcase
    booth_nxt = {acc_sum[32], acc_sum, prod[32:1]};
  end

  // One restoring step on magnitudes: shift in next dividend bit, trial subtract.
  assign div_sh   = {rem_r, quo_r[31]};
  assign div_diff = div_sh - {1'b0, m_r};
  assign quo_fin  = (sign_a ^ sign_b) ? -quo_r : quo_r;
  assign rem_fin  = sign_a ? -rem_r : rem_r;

`ifdef ALU_MULTDIV_FAST_MULT_EN
  logic signed [63:0] fast_p;
  assign fast_p = $signed(src_a) * $signed(src_b);
`endif

  // NOTE: working registers are fully loaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= (op == OP_DIV);
      sign_a <= src_a[31];
      sign_b <= src_b[31];
      dz_r   <= (op == OP_DIV) && (src_b == 32'd0);
      if (op == OP_DIV) begin
        m_r   <= src_b[31] ? -src_b : src_b;
        quo_r <= src_a[31] ? -src_a : src_a;
        rem_r <= 32'd0;
      end else begin
        m_r  <= src_a;
`ifdef ALU_MULTDIV_FAST_MULT_EN
        prod <= {fast_p[63], fast_p, 1'b0};
`else
        prod <= {33'd0, src_b, 1'b0};
`endif
      end
    end else if (state == S_MULT) begin
      prod <= booth_nxt;
    end else if (state == S_DIV) begin
      rem_r <= div_diff[32] ? div_sh[31:0] : div_diff[31:0];
      quo_r <= {quo_r[30:0], ~div_diff[32]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 5'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= 32'd0;
      lo_out   <= 32'd0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt      <= 5'd0;
        div_zero <= 1'b0;
      end else if (state == S_MULT || state == S_DIV) begin
        cnt <= cnt + 5'd1;
      end
      if (state == S_FINISH) begin
        done <= 1'b1;
        if (dz_r) begin
          div_zero <= 1'b1;
        end else if (is_div) begin
          hi_out <= rem_fin;
          lo_out <= quo_fin;
        end else begin
          hi_out <= prod[64:33];
          lo_out <= prod[32:1];
        end
      end
    end
  end

endmodule
